rf_writeback_arbiter: RTL
=========================

// Module: rf_writeback_arbiter
// PURPOSE
//  Owns the register-file write port of the 16-bit CPU. Arbitrates between ALU results and memory load returns.
//  Buffers ALU results in a small FIFO and drives the registered write strobe, address, data and the RFSelect source code.
//  Memory loads have priority. A burst limiter prevents ALU starvation.
// PARAMETERS
//  DATA_W        16  write data width
//  ADDR_W        4   register address width
//  FIFO_DEPTH    4   ALU result buffer entries (power of 2, >=2)
//  MAX_MEM_BURST 3   max consecutive memory grants while the ALU FIFO is non-empty
// PORTS
//  Clk          in   1       clock, all state on rising edge
//  ResetN       in   1       synchronous reset, active-low
//  AluValid     in   1       ALU result offered
//  AluReady     out  1       ALU result accepted when AluValid&&AluReady
//  AluAddr      in   ADDR_W  destination register of ALU result
//  ALUQ         in   DATA_W  ALU result
//  MemValid     in   1       load data offered
//  MemReady     out  1       load accepted when MemValid&&MemReady
//  MemAddr      in   ADDR_W  destination register of load
//  ReadData     in   DATA_W  load data
//  RFWriteEn    out  1       register-file write strobe
//  RFWriteAddr  out  ADDR_W  write address
//  WriteData    out  DATA_W  write data
//  RFSelect     out  1       source of current write: 0=ALU, 1=memory
// BEHAVIOUR
//  - Reset (ResetN low at edge): RFWriteEn=0, RFWriteAddr=0, WriteData=0, RFSelect=0. FIFO emptied, MemHold invalid, BurstCnt=0, state IDLE.
//    AluReady and MemReady are 0 while ResetN is low. Reset mid-burst discards all buffered writes.
//  - AluReady = !fifo_full. Accepted ALU entries are pushed into the FIFO. The head is eligible the cycle after the push.
//  - MemReady = !MemHold.valid. Mem candidate = MemHold if valid, else incoming accepted load.
//  - Each cycle at most one grant. The granted entry appears on the registered outputs after the next edge.
//    Latency: memory 1 cycle; ALU 2 cycles minimum.
//  - A mem candidate that is not granted is captured into MemHold (1 entry). It is retired before any new load.
//  - FSM (state, BurstCnt[clog2(MAX_MEM_BURST+1)-1:0]):
//     IDLE: mem cand -> grant mem, go MEMRUN, BurstCnt=1. Else FIFO non-empty -> grant ALU, stay IDLE.
//     MEMRUN: mem cand && (fifo empty || BurstCnt<MAX_MEM_BURST) -> grant mem, BurstCnt++ (saturating).
//       mem cand && fifo non-empty && BurstCnt==MAX_MEM_BURST -> grant ALU, go ALUFORCE.
//       no mem cand -> as IDLE, BurstCnt=0.
//     ALUFORCE: one-cycle state, grants nothing itself. Next cycle evaluated as IDLE with BurstCnt=0.
//       The pending mem cand (now in MemHold) wins that cycle.
//  - BurstCnt clears whenever the FIFO is empty.
//  - RFWriteEn=0 in cycles with no grant. RFWriteAddr, WriteData and RFSelect hold their last values.
//  - Simultaneous push and pop on a full FIFO: not allowed, because AluReady is already low when full.
//    Push and pop on a non-full FIFO in the same cycle are both legal; occupancy is unchanged.
//  - FIFO pointers wrap modulo FIFO_DEPTH. Occupancy counter is clog2(FIFO_DEPTH)+1 bits.
//  - Two writes to the same address retire in grant order. The later grant is the one that persists.
// CONFIGURATION
//  - WB_STATS_EN defined: adds output StallCnt [15:0].
//    StallCnt increments (saturating at 16'hFFFF) each cycle AluValid&&!AluReady or MemValid&&!MemReady.
//    Reset clears it to 0.
//  - WB_STATS_EN undefined: the port and counter are absent. Arbitration is identical.
// STRUCTURE
//  - Package wb_pkg: typedef enum logic[1:0] {WB_IDLE, WB_MEMRUN, WB_ALUFORCE} wb_state_t.
//    Also typedef struct packed {logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data;} wb_entry_t.
//    Also constants WB_SEL_ALU=1'b0 and WB_SEL_MEM=1'b1.
//  - Sub-module wb_alu_fifo: parameterised sync FIFO of wb_entry_t, DEPTH=FIFO_DEPTH.
//    Ports: push, pop, full, empty, head.
// TESTING
//  - ALU only: AluValid with Addr=3, ALUQ=16'h1234 -> two cycles later RFWriteEn=1, Addr=3, WriteData=16'h1234, RFSelect=0.
//  - Load only: MemValid with Addr=5, ReadData=16'hBEEF -> next cycle RFWriteEn=1, Addr=5, WriteData=16'hBEEF, RFSelect=1.
//  - Fairness: FIFO holding 1 entry, MemValid held high for 6 cycles ->
//    grant order M,M,M,A,M,M,M; MemReady low exactly one cycle.
//  - Backpressure: 5 back-to-back ALU results during a continuous load burst ->
//    AluReady drops after the 4th push; no entry is lost or reordered.
//  - Reset mid-op: FIFO with 3 entries plus MemHold valid, ResetN low one cycle ->
//    no RFWriteEn afterwards, all outputs 0.
//  - WB_STATS_EN: 2 stalled ALU cycles and 1 stalled mem cycle -> StallCnt=3.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types for the register-file writeback arbiter.
// Entry layout, FSM states and RFSelect source codes.
package wb_pkg;

    localparam int WB_DATA_W = 16;
    localparam int WB_ADDR_W = 4;

    localparam logic WB_SEL_ALU = 1'b0;
    localparam logic WB_SEL_MEM = 1'b1;

    typedef enum logic [1:0] {
        WB_IDLE,
        WB_MEMRUN,
        WB_ALUFORCE
    } wb_state_t;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_alu_fifo.sv
// Synchronous FIFO of pending ALU writeback entries.
// Head is valid whenever empty is low; pointers wrap modulo DEPTH.
module wb_alu_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  wb_entry_t din,
    input  logic      pop,
    output logic      full,
    output logic      empty,
    output wb_entry_t head
);

    localparam int PW = $clog2(DEPTH);

    wb_entry_t      r_mem [DEPTH];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [PW:0]    r_count;
    logic           w_push;
    logic           w_pop;

    assign full   = (r_count == (PW+1)'(DEPTH));
    assign empty  = (r_count == '0);
    assign head   = r_mem[r_rd_ptr];
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Register-file write port owner: memory loads win, ALU results are queued.
// Optional WB_STATS_EN adds a saturating StallCnt output.
module rf_writeback_arbiter
    import wb_pkg::*;
#(
    parameter int DATA_W        = WB_DATA_W,
    parameter int ADDR_W        = WB_ADDR_W,
    parameter int FIFO_DEPTH    = 4,
    parameter int MAX_MEM_BURST = 3
) (
    input  logic              Clk,
    input  logic              ResetN,
    input  logic              AluValid,
    output logic              AluReady,
    input  logic [ADDR_W-1:0] AluAddr,
    input  logic [DATA_W-1:0] ALUQ,
    input  logic              MemValid,
    output logic              MemReady,
    input  logic [ADDR_W-1:0] MemAddr,
    input  logic [DATA_W-1:0] ReadData,
    output logic              RFWriteEn,
    output logic [ADDR_W-1:0] RFWriteAddr,
    output logic [DATA_W-1:0] WriteData,
    output logic              RFSelect
`ifdef WB_STATS_EN
    ,
    output logic [15:0]       StallCnt
`endif
);

    localparam int CW = $clog2(MAX_MEM_BURST + 1);
    localparam logic [CW-1:0] BURST_MAX = CW'(MAX_MEM_BURST);

    wb_state_t         r_state;
    wb_state_t         w_state_nxt;
    logic [CW-1:0]     r_burst;
    logic [CW-1:0]     w_burst_nxt;
    wb_entry_t         r_hold;
    logic              r_hold_vld;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_sel;

    logic      w_fifo_full;
    logic      w_fifo_empty;
    wb_entry_t w_head;
    wb_entry_t w_alu_in;
    wb_entry_t w_mem_in;
    wb_entry_t w_cand;
    logic      w_alu_push;
    logic      w_mem_acc;
    logic      w_mem_cand;
    logic      w_gnt_mem;
    logic      w_gnt_alu;

    assign AluReady   = ResetN && !w_fifo_full;
    assign MemReady   = ResetN && !r_hold_vld;
    assign w_alu_push = AluValid && AluReady;
    assign w_mem_acc  = MemValid && MemReady;
    assign w_mem_cand = r_hold_vld || w_mem_acc;
    assign w_alu_in   = '{addr: AluAddr, data: ALUQ};
    assign w_mem_in   = '{addr: MemAddr, data: ReadData};
    assign w_cand     = r_hold_vld ? r_hold : w_mem_in;

    wb_alu_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (Clk),
        .rst_n (ResetN),
        .push  (w_alu_push),
        .din   (w_alu_in),
        .pop   (w_gnt_alu),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .head  (w_head)
    );

    // ALUFORCE has no rule of its own: it arbitrates like IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_burst_nxt = r_burst;
        w_gnt_mem   = 1'b0;
        w_gnt_alu   = 1'b0;
        unique case (r_state)
            WB_MEMRUN: begin
                if (w_mem_cand && (w_fifo_empty || r_burst < BURST_MAX)) begin
                    w_gnt_mem = 1'b1;
                    if (r_burst != BURST_MAX) begin
                        w_burst_nxt = r_burst + 1'b1;
                    end
                end else if (w_mem_cand) begin
                    w_gnt_alu   = 1'b1;
                    w_state_nxt = WB_ALUFORCE;
                end else begin
                    w_gnt_alu   = !w_fifo_empty;
                    w_state_nxt = WB_IDLE;
                    w_burst_nxt = '0;
                end
            end
            default: begin
                if (w_mem_cand) begin
                    w_gnt_mem   = 1'b1;
                    w_state_nxt = WB_MEMRUN;
                    w_burst_nxt = CW'(1);
                end else begin
                    w_gnt_alu   = !w_fifo_empty;
                    w_state_nxt = WB_IDLE;
                    w_burst_nxt = '0;
                end
            end
        endcase
        if (w_fifo_empty) begin
            w_burst_nxt = '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            r_state    <= WB_IDLE;
            r_burst    <= '0;
            r_hold_vld <= 1'b0;
            r_hold     <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_sel      <= WB_SEL_ALU;
        end else begin
            r_state <= w_state_nxt;
            r_burst <= w_burst_nxt;
            r_we    <= w_gnt_mem || w_gnt_alu;
            if (w_gnt_mem) begin
                r_hold_vld <= 1'b0;
            end else if (w_mem_acc) begin
                r_hold_vld <= 1'b1;
                r_hold     <= w_mem_in;
            end
            if (w_gnt_mem) begin
                r_addr <= w_cand.addr;
                r_data <= w_cand.data;
                r_sel  <= WB_SEL_MEM;
            end else if (w_gnt_alu) begin
                r_addr <= w_head.addr;
                r_data <= w_head.data;
                r_sel  <= WB_SEL_ALU;
            end
        end
    end

    assign RFWriteEn   = r_we;
    assign RFWriteAddr = r_addr;
    assign WriteData   = r_data;
    assign RFSelect    = r_sel;

`ifdef WB_STATS_EN
    logic [15:0] r_stall_cnt;
    logic        w_stall;

    assign w_stall = (AluValid && !AluReady) || (MemValid && !MemReady);

    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            r_stall_cnt <= '0;
        end else if (w_stall && r_stall_cnt != 16'hFFFF) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign StallCnt = r_stall_cnt;
`endif

endmodule
